// File: rtl/hazard_control_unit_v2.sv
// rtl/hazard_control_unit_v2.sv - ID-stage load-use/branch/MDU/mem-wait hazard control with stall counter
module hazard_control_unit_v2 #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int MDU_CW  = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] IF_ID_rs,
  input  logic [REG_AW-1:0] IF_ID_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch,
  input  logic              id_branch_taken,
  input  logic              id_mdu_op,
  input  logic              id_reads_hilo,
  input  logic              ID_EX_mem_read,
  input  logic              ID_EX_reg_write,
  input  logic [REG_AW-1:0] ID_EX_dest,
  input  logic              EX_MEM_mem_read,
  input  logic [REG_AW-1:0] EX_MEM_dest,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  input  logic              perf_clr,
  output logic              pc_stall,
  output logic              IF_ID_stall,
  output logic              IF_ID_flush,
  output logic              mux_control_hazard,
  output logic              freeze,
  output logic [2:0]        stall_cause,
  output logic              mdu_busy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [MDU_CW-1:0] LAT = MDU_CW'(MDU_LAT);

  logic [MDU_CW-1:0] mdu_cnt;
  logic              ex_hit;
  logic              mem_hit;
  logic              data_stall;
  logic              mdu_stall;
  logic              mem_wait;
  logic              mdu_issue;

  // Operand match against EX and MEM destinations; $0 never creates a dependency
  always_comb begin
    ex_hit  = (id_use_rs && IF_ID_rs == ID_EX_dest  && ID_EX_dest  != '0) ||
              (id_use_rt && IF_ID_rt == ID_EX_dest  && ID_EX_dest  != '0);
    mem_hit = (id_use_rs && IF_ID_rs == EX_MEM_dest && EX_MEM_dest != '0) ||
              (id_use_rt && IF_ID_rt == EX_MEM_dest && EX_MEM_dest != '0);
  end

  // Hazard conditions: load-use, branch operands not yet available in ID, MDU busy, memory wait
  always_comb begin
    data_stall = (ID_EX_mem_read && ex_hit) ||
                 (id_branch && ID_EX_reg_write && ex_hit) ||
                 (id_branch && EX_MEM_mem_read && mem_hit);
    mdu_busy   = (mdu_cnt != '0);
    mdu_stall  = mdu_busy && (id_reads_hilo || id_mdu_op);
    mem_wait   = dmem_req && !dmem_ready;
    mdu_issue  = id_mdu_op && !data_stall && !mdu_stall && !mem_wait;
    stall_cause = {mem_wait, mdu_stall, data_stall};
  end

  // Output priority: mem wait freezes everything (no bubble), then ID stalls bubble, then taken-branch flush
  always_comb begin
    pc_stall           = 1'b0;
    IF_ID_stall        = 1'b0;
    IF_ID_flush        = 1'b0;
    mux_control_hazard = 1'b0;
    freeze             = 1'b0;
    if (mem_wait) begin
      freeze      = 1'b1;
      pc_stall    = 1'b1;
      IF_ID_stall = 1'b1;
    end else if (data_stall || mdu_stall) begin
      pc_stall           = 1'b1;
      IF_ID_stall        = 1'b1;
      mux_control_hazard = 1'b1;
    end else begin
      IF_ID_flush = id_branch && id_branch_taken;
    end
  end

  // MDU latency countdown: loads on issue, keeps draining even while the pipeline is frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_cnt <= '0;
    end else if (mdu_issue) begin
      mdu_cnt <= LAT;
    end else if (mdu_cnt != '0) begin
      mdu_cnt <= mdu_cnt - 1'b1;
    end
  end

  // Saturating count of PC-stall cycles, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if (pc_stall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit_v2.sv
// tb/tb_hazard_control_unit_v2.sv - directed self-checking bench for hazard_control_unit_v2
module tb_hazard_control_unit_v2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_dest, EX_MEM_dest;
  logic       id_use_rs, id_use_rt, id_branch, id_branch_taken, id_mdu_op, id_reads_hilo;
  logic       ID_EX_mem_read, ID_EX_reg_write, EX_MEM_mem_read;
  logic       dmem_req, dmem_ready, perf_clr;
  logic       pc_stall, IF_ID_stall, IF_ID_flush, mux_control_hazard, freeze, mdu_busy;
  logic [2:0] stall_cause;
  logic [2:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  hazard_control_unit_v2 #(.REG_AW(5), .MDU_LAT(4), .MDU_CW(3), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch(id_branch), .id_branch_taken(id_branch_taken),
    .id_mdu_op(id_mdu_op), .id_reads_hilo(id_reads_hilo),
    .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_dest(ID_EX_dest),
    .EX_MEM_mem_read(EX_MEM_mem_read), .EX_MEM_dest(EX_MEM_dest),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
    .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
    .mux_control_hazard(mux_control_hazard), .freeze(freeze),
    .stall_cause(stall_cause), .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    IF_ID_rs = 0; IF_ID_rt = 0; ID_EX_dest = 0; EX_MEM_dest = 0;
    id_use_rs = 0; id_use_rt = 0; id_branch = 0; id_branch_taken = 0;
    id_mdu_op = 0; id_reads_hilo = 0;
    ID_EX_mem_read = 0; ID_EX_reg_write = 0; EX_MEM_mem_read = 0;
    dmem_req = 0; dmem_ready = 0; perf_clr = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_stall_cycles", stall_cycles, 0);
    chk("rst_mdu_busy", mdu_busy, 0);
    chk("rst_pc_stall", pc_stall, 0);
    chk("rst_cause", stall_cause, 0);
    rst_n = 1'b1;
    tick();

    // load-use on rs
    ID_EX_mem_read = 1; ID_EX_dest = 8; IF_ID_rs = 8; id_use_rs = 1; #1;
    chk("lu_pc_stall", pc_stall, 1);
    chk("lu_ifid_stall", IF_ID_stall, 1);
    chk("lu_bubble", mux_control_hazard, 1);
    chk("lu_cause", stall_cause, 3'b001);
    chk("lu_freeze", freeze, 0);
    ID_EX_dest = 0; IF_ID_rs = 0; #1;
    chk("lu_r0_pc_stall", pc_stall, 0);
    chk("lu_r0_cause", stall_cause, 0);
    ID_EX_dest = 8; IF_ID_rs = 8; id_use_rs = 0; #1;
    chk("lu_nouse_pc_stall", pc_stall, 0);
    IF_ID_rt = 8; id_use_rt = 1; #1;
    chk("lu_rt_pc_stall", pc_stall, 1);

    // branch with load result still in MEM, then conflict gone
    clear_inputs();
    id_branch = 1; id_branch_taken = 1; EX_MEM_mem_read = 1; EX_MEM_dest = 9;
    IF_ID_rt = 9; id_use_rt = 1; #1;
    chk("br_mem_pc_stall", pc_stall, 1);
    chk("br_mem_flush", IF_ID_flush, 0);
    chk("br_mem_bubble", mux_control_hazard, 1);
    EX_MEM_mem_read = 0; #1;
    chk("br_free_flush", IF_ID_flush, 1);
    chk("br_free_pc_stall", pc_stall, 0);
    ID_EX_reg_write = 1; ID_EX_dest = 9; #1;
    chk("br_ex_pc_stall", pc_stall, 1);
    chk("br_ex_flush", IF_ID_flush, 0);
    id_branch = 0; id_branch_taken = 0; #1;
    chk("alu_ex_no_stall", pc_stall, 0);

    // memory wait together with load-use
    clear_inputs();
    ID_EX_mem_read = 1; ID_EX_dest = 8; IF_ID_rs = 8; id_use_rs = 1;
    dmem_req = 1; dmem_ready = 0; #1;
    chk("mw_freeze", freeze, 1);
    chk("mw_bubble", mux_control_hazard, 0);
    chk("mw_cause", stall_cause, 3'b101);
    chk("mw_pc_stall", pc_stall, 1);
    dmem_ready = 1; #1;
    chk("mwr_freeze", freeze, 0);
    chk("mwr_bubble", mux_control_hazard, 1);
    chk("mwr_cause", stall_cause, 3'b001);

    // MDU: mult issues in cycle 0, mfhi waits cycles 1..4
    clear_inputs();
    perf_clr = 1;
    tick();
    perf_clr = 0;
    chk("mdu_pre_clr", stall_cycles, 0);
    id_mdu_op = 1; #1;
    chk("mdu_c0_busy", mdu_busy, 0);
    chk("mdu_c0_pc_stall", pc_stall, 0);
    tick();
    id_mdu_op = 0; id_reads_hilo = 1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("mdu_c%0d_busy", c), mdu_busy, 1);
      chk($sformatf("mdu_c%0d_pc_stall", c), pc_stall, 1);
      tick();
    end
    chk("mdu_c5_busy", mdu_busy, 0);
    chk("mdu_c5_pc_stall", pc_stall, 0);
    chk("mdu_c5_cause", stall_cause, 0);
    chk("mdu_stall_cycles", stall_cycles, 4);

    // saturating counter with CNT_W=3
    clear_inputs();
    perf_clr = 1;
    tick();
    perf_clr = 0;
    chk("cnt_clr0", stall_cycles, 0);
    ID_EX_mem_read = 1; ID_EX_dest = 8; IF_ID_rs = 8; id_use_rs = 1;
    tick(); tick(); tick();
    chk("cnt_3", stall_cycles, 3);
    for (int i = 0; i < 7; i++) tick();
    chk("cnt_sat", stall_cycles, 7);
    perf_clr = 1;
    tick();
    chk("cnt_clr_under_stall", stall_cycles, 0);
    perf_clr = 0;

    // asynchronous reset mid MDU count
    clear_inputs();
    id_mdu_op = 1;
    tick();
    id_mdu_op = 0; id_reads_hilo = 1;
    tick(); tick();
    chk("rmid_busy_pre", mdu_busy, 1);
    chk("rmid_cycles_pre", stall_cycles, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_busy", mdu_busy, 0);
    chk("rmid_cycles", stall_cycles, 0);
    chk("rmid_pc_stall", pc_stall, 0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_mfhi_stall", pc_stall, 0);
    chk("post_rst_cycles", stall_cycles, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
